uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_ctrl_pkg.sv | 12 +
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
package uart_ctrl_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle of the UART transmit arbiter.
// The slave side is the arbiter; the master side is its environment.
interface uart_tx_arbiter_if
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0]         req_pulse;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic                       tx_busy;
  logic                       tx_start;
  logic [DATA_W-1:0]          tx_data;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic [NUM_REQ-1:0]         pending;
  logic [NUM_REQ-1:0]         overrun;
  logic                       timeout_err;

  modport master (
    output req_pulse, req_data, tx_busy,
    input  tx_start, tx_data, grant_id, pending, overrun, timeout_err
  );
  modport slave (
    input  req_pulse, req_data, tx_busy,
    output tx_start, tx_data, grant_id, pending, overrun, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first set pending bit after 'last', wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);
  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (pending[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// UART transmit arbiter: one-deep slot per requester, round-robin grant.
// Optional macro UART_ARB_TIMEOUT_EN adds a tx_busy no-response timeout.
module uart_tx_arbiter_core
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int GID_W = $clog2(NUM_REQ);

  arb_state_e                     state;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot;
  logic [NUM_REQ-1:0]             pending, overrun;
  logic [GID_W-1:0]               grant_id;
  logic                           tx_start;
  logic [DATA_W-1:0]              tx_data;
  logic                           pick_vld, grant_now, to_hit;
  logic [GID_W-1:0]               pick_idx;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(GID_W)) u_pick (
    .pending (pending),
    .last    (grant_id),
    .valid   (pick_vld),
    .idx     (pick_idx)
  );

  assign grant_now = (state == IDLE) && pick_vld;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout_err;

  assign to_hit = (state == WAIT_BUSY) && !bus.tx_busy &&
                  (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_BUSY && !bus.tx_busy) ? to_cnt + 1'b1 : '0;
      if (to_hit) timeout_err <= 1'b1;
    end
  end
  assign bus.timeout_err = timeout_err;
`else
  assign to_hit          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= GID_W'(NUM_REQ - 1);
      pending  <= '0;
      overrun  <= '0;
      slot     <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (pick_vld) begin
          state    <= START;
          tx_start <= 1'b1;
          tx_data  <= slot[pick_idx];
          grant_id <= pick_idx;
        end
        START:     state <= WAIT_BUSY;
        WAIT_BUSY: if (bus.tx_busy) state <= WAIT_DONE;
                   else if (to_hit) state <= IDLE;
        WAIT_DONE: if (!bus.tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
      // The slot being granted this edge frees up, so a same-edge pulse refills it.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_pulse[i] && (!pending[i] || (grant_now && pick_idx == GID_W'(i)))) begin
          slot[i]    <= bus.req_data[i*DATA_W +: DATA_W];
          pending[i] <= 1'b1;
        end else begin
          if (grant_now && pick_idx == GID_W'(i)) pending[i] <= 1'b0;
          if (bus.req_pulse[i]) overrun[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.tx_start = tx_start;
  assign bus.tx_data  = tx_data;
  assign bus.grant_id = grant_id;
  assign bus.pending  = pending;
  assign bus.overrun  = overrun;
endmodule

module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_pulse,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         pending,
  output logic [NUM_REQ-1:0]         overrun,
  output logic                       timeout_err
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  assign bus.req_pulse = req_pulse;
  assign bus.req_data  = req_data;
  assign bus.tx_busy   = tx_busy;
  assign tx_start      = bus.tx_start;
  assign tx_data       = bus.tx_data;
  assign grant_id      = bus.grant_id;
  assign pending       = bus.pending;
  assign overrun       = bus.overrun;
  assign timeout_err   = bus.timeout_err;

  uart_tx_arbiter_core #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: grant vector table plus scoreboard.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  logic model_busy = 1'b0;
  assign bus.tx_busy = model_busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_pulse   (bus.req_pulse),
    .req_data    (bus.req_data),
    .tx_busy     (bus.tx_busy),
    .tx_start    (bus.tx_start),
    .tx_data     (bus.tx_data),
    .grant_id    (bus.grant_id),
    .pending     (bus.pending),
    .overrun     (bus.overrun),
    .timeout_err (bus.timeout_err)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic [3:0]      mask;
    logic [31:0]     data;
    int              n;
    logic [3:0][1:0] ids;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   busy_en = 1'b1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(logic [1:0] id, logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic send(logic [3:0] m, logic [31:0] d);
    bus.req_pulse = m;
    bus.req_data  = d;
    @(negedge clk);
    bus.req_pulse = '0;
  endtask

  task automatic wait_drain(string nm);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_drain"}, sb.size(), 0);
    sb.delete();
    repeat (14) @(negedge clk);
  endtask

  // Transmitter model: busy rises one cycle after tx_start, lasts 10 cycles.
  initial begin
    int  left;
    bit  arm;
    left = 0;
    arm  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        model_busy = 1'b0;
        left = 0;
        arm  = 1'b0;
      end else begin
        if (left > 0) begin
          left--;
          if (left == 0) model_busy = 1'b0;
        end
        if (arm) begin
          arm = 1'b0;
          model_busy = 1'b1;
          left = 10;
        end
        if (bus.tx_start === 1'b1 && busy_en) arm = 1'b1;
      end
    end
  end

  // Scoreboard: every tx_start must match the oldest expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tx_start: got grant %0d data %0h, expected no start",
                   bus.grant_id, bus.tx_data);
        end else begin
          e = sb.pop_front();
          check("sb_grant", 32'(bus.grant_id), 32'(e.id));
          check("sb_data", 32'(bus.tx_data), 32'(e.d));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vec [6];
    logic [31:0] sh;
    int          starts;

    vec[0] = '{mask: 4'b1011, data: 32'hA300_A1A0, n: 3, ids: {2'd0, 2'd3, 2'd1, 2'd0}};
    vec[1] = '{mask: 4'b0100, data: 32'h0041_0000, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd2}};
    vec[2] = '{mask: 4'b1111, data: 32'hD3D2_D1D0, n: 4, ids: {2'd2, 2'd1, 2'd0, 2'd3}};
    vec[3] = '{mask: 4'b0001, data: 32'h0000_00E0, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd0}};
    vec[4] = '{mask: 4'b0110, data: 32'h00F2_F100, n: 2, ids: {2'd0, 2'd0, 2'd2, 2'd1}};
    vec[5] = '{mask: 4'b1001, data: 32'h9300_0090, n: 2, ids: {2'd0, 2'd0, 2'd0, 2'd3}};

    bus.req_pulse = '0;
    bus.req_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_grant_id", 32'(bus.grant_id), 3);
    check("rst_pending", 32'(bus.pending), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_timeout_err", 32'(bus.timeout_err), 0);
    reset = 1'b0;
    @(negedge clk);

    // Grant-order table
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vec[v].n; k++) begin
        sh = vec[v].data >> (32'(vec[v].ids[k]) * 8);
        push(vec[v].ids[k], sh[7:0]);
      end
      send(vec[v].mask, vec[v].data);
      wait_drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_pending", v), 32'(bus.pending), 0);
      check($sformatf("vec%0d_overrun", v), 32'(bus.overrun), 0);
    end

    // Single request latency: tx_start two cycles after the pulse
    push(2'd2, 8'h41);
    send(4'b0100, 32'h0041_0000);
    check("lat_start_early", 32'(bus.tx_start), 0);
    check("lat_pending_set", 32'(bus.pending), 32'b0100);
    @(negedge clk);
    check("lat_tx_start", 32'(bus.tx_start), 1);
    check("lat_tx_data", 32'(bus.tx_data), 32'h41);
    check("lat_grant_id", 32'(bus.grant_id), 2);
    check("lat_pending_clr", 32'(bus.pending), 0);
    @(negedge clk);
    check("lat_start_one_cycle", 32'(bus.tx_start), 0);
    wait_drain("lat");

    // Overrun: second pulse on a still-pending requester is dropped
    push(2'd0, 8'h55);
    send(4'b0001, 32'h0000_0055);
    repeat (3) @(negedge clk);
    push(2'd1, 8'h10);
    send(4'b0010, 32'h0000_1000);
    check("ovr_pending_1", 32'(bus.pending), 32'b0010);
    check("ovr_none_yet", 32'(bus.overrun), 0);
    repeat (2) @(negedge clk);
    send(4'b0010, 32'h0000_1100);
    check("ovr_flag", 32'(bus.overrun), 32'b0010);
    check("ovr_pending_kept", 32'(bus.pending), 32'b0010);
    wait_drain("ovr");
    check("ovr_sticky", 32'(bus.overrun), 32'b0010);
    check("ovr_pending_clr", 32'(bus.pending), 0);

    // Reset during WAIT_DONE with requests pending
    push(2'd3, 8'h77);
    send(4'b1000, 32'h7700_0000);
    repeat (5) @(negedge clk);
    send(4'b1010, 32'h2200_1100);
    check("rstwd_pending", 32'(bus.pending), 32'b1010);
    check("rstwd_busy", 32'(model_busy), 1);
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    check("rstwd_tx_start", 32'(bus.tx_start), 0);
    check("rstwd_tx_data", 32'(bus.tx_data), 0);
    check("rstwd_grant_id", 32'(bus.grant_id), 3);
    check("rstwd_pending_clr", 32'(bus.pending), 0);
    check("rstwd_overrun_clr", 32'(bus.overrun), 0);
    check("rstwd_timeout_err", 32'(bus.timeout_err), 0);
    reset = 1'b0;
    starts = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) starts++;
    end
    check("rstwd_no_start", starts, 0);

    // Transmitter never answers
    busy_en = 1'b0;
    push(2'd0, 8'h5A);
    send(4'b0001, 32'h0000_005A);
    @(negedge clk);
    check("to_tx_start", 32'(bus.tx_start), 1);
    repeat (15) @(negedge clk);
    check("to_err_before", 32'(bus.timeout_err), 0);
    @(negedge clk);
`ifdef UART_ARB_TIMEOUT_EN
    check("to_err_set", 32'(bus.timeout_err), 1);
    push(2'd2, 8'h66);
    send(4'b0100, 32'h0066_0000);
    repeat (10) @(negedge clk);
    check("to_regrant_pending", 32'(bus.pending), 0);
    check("to_regrant_sb", sb.size(), 0);
`else
    check("to_err_tied", 32'(bus.timeout_err), 0);
    send(4'b0100, 32'h0066_0000);
    repeat (40) @(negedge clk);
    check("to_stuck_pending", 32'(bus.pending), 32'b0100);
    check("to_stuck_err", 32'(bus.timeout_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
